pipelined_barrel_shifter: RTL and testbench
===========================================

Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the team's 8-bit combinational rotate-right shifter. It supports rotate-right, rotate-left, logical-right and arithmetic-right shifts for any power-of-two WIDTH. Each log2(WIDTH) shift stage has its own register and a valid/ready handshake with per-stage backpressure. It sits in the DA/LMS datapath wherever operands need variable scaling or realignment at full clock rate.

Parameters:
WIDTH, 16, data width in bits; power of two, at least 2.
AMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages (derived; do not override).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  input beat present
in_ready  output  1  block can accept the input beat this cycle
in_data  input  WIDTH  operand
in_amt  input  AMT_W  shift amount, 0..WIDTH-1
in_mode  input  2  00 ROR, 01 ROL, 10 LSR (zero fill), 11 ASR (sign fill)
out_valid  output  1  result present
out_ready  input  1  downstream accepts the result
out_data  output  WIDTH  shifted result
out_zero  output  1  out_data == 0, registered with the data

Behaviour:
- Datapath: stage k (k = 0..AMT_W-1) holds valid[k], data[k], and the unused upper amount bits and mode.
- Stage k shifts its input by 2^k positions in the selected mode when amount bit k is 1. Otherwise it passes the data through.
- Stage 0 takes its input from the in_* ports. Output ports are driven directly from the last stage's registers; there is no output mux.
- Mode semantics:
  - ROR by n gives {x[n-1:0], x[W-1:n]}.
  - ROL is the mirror of ROR.
  - LSR fills with 0.
  - ASR fills with x[W-1] of the original operand. Sign is preserved across stages because every stage fills from the current MSB.
- Amount 0 gives the identity in every mode.
- Handshake:
  - stage_ready[k] = !valid[k] || stage_ready[k+1], with stage_ready[AMT_W] = out_ready. This is a combinational chain.
  - in_ready = stage_ready[0].
  - A transfer occurs when valid && ready are both high at a rising edge.
  - A stage loads when its ready is high. It takes valid from its predecessor, so a bubble loads as valid = 0. Data registers update only when the incoming valid is 1.
- Latency: a beat accepted at edge n appears with out_valid = 1 after edge n + AMT_W - 1, provided no stall occurs. Throughput is one beat per cycle while out_ready = 1.
- Backpressure:
  - With out_ready = 0, the pipeline compresses bubbles and holds up to AMT_W beats.
  - in_ready drops only when every stage is valid.
  - Ordering is strictly preserved. No beat is dropped or duplicated.
  - out_data and out_zero hold stable while out_valid && !out_ready.
- Simultaneous events: when a full pipeline sees out_ready = 1, it accepts a new input in the same cycle (in_ready = 1).
- in_amt must be in range; the full AMT_W bits are always used, so no out-of-range amount exists.
- Reset (asynchronous assert, synchronous-safe deassert in the system):
  - All valid[k] = 0 and all data registers = 0.
  - out_valid = 0, out_data = 0, out_zero = 0 (registered value; an invalid output is don't-care for consumers).
  - in_ready = 1 immediately while rst_n = 0, because no stage is valid.
  - Reset mid-stream discards all in-flight beats; no partial results emerge after release.
- No combinational path from in_data to out_data. The only combinational outputs are in_ready from out_ready and the valid flags.

Test Plan:
- WIDTH=8, single beats with in_data=8'hB4, in_amt=3, out_ready=1: ROR gives 8'h96, ROL 8'hA5, LSR 8'h16, ASR 8'hF6. Each result reaches out_valid exactly 3 cycles after acceptance.
- WIDTH=8, in_amt=0, all four modes with in_data=8'h81: out_data=8'h81 every time. in_data=8'h01 with LSR amt 1 gives 8'h00 and out_zero=1.
- Streaming: 64 back-to-back random beats with out_ready=1, checked against a reference model. Results arrive one per cycle, in order, with no gaps after the initial latency.
- Backpressure: hold out_ready=0 while streaming. Exactly 3 beats are accepted, then in_ready=0. out_data is stable while stalled. Releasing out_ready drains the pipeline in order with no loss.
- Random out_ready/in_valid toggling over 1000 beats, checked by scoreboard: zero mismatches, and in_ready equals the expected stage_ready[0] every cycle.
- Assert rst_n=0 with 3 beats in flight: out_valid=0 and out_data=0 immediately. After release, no stale beats appear and the first new beat emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, each with a
// valid/ready handshake so any stage can absorb backpressure independently.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    typedef enum logic [1:0] {
        MODE_ROR = 2'b00,
        MODE_ROL = 2'b01,
        MODE_LSR = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    logic [AMT_W-1:0] valid_q;
    logic [WIDTH-1:0] data_q [AMT_W];
    logic [AMT_W-1:0] amt_q  [AMT_W];
    mode_e            mode_q [AMT_W];
    logic             zero_q;

    logic [AMT_W:0]   stage_ready;
    logic [AMT_W-1:0] valid_d;
    logic [WIDTH-1:0] src_data [AMT_W];
    logic [WIDTH-1:0] data_d   [AMT_W];
    logic [AMT_W-1:0] amt_d    [AMT_W];
    mode_e            mode_d   [AMT_W];

    // A stage can load when it is empty or its successor is moving this cycle.
    always_comb begin
        stage_ready        = '0;
        stage_ready[AMT_W] = out_ready;
        for (int unsigned i = 0; i < AMT_W; i++) begin
            stage_ready[AMT_W-1-i] = !valid_q[AMT_W-1-i] || stage_ready[AMT_W-i];
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < AMT_W; k++) begin
            if (k == 0) begin
                valid_d[k]  = in_valid;
                src_data[k] = in_data;
                amt_d[k]    = in_amt;
                mode_d[k]   = mode_e'(in_mode);
            end else begin
                valid_d[k]  = valid_q[k-1];
                src_data[k] = data_q[k-1];
                amt_d[k]    = amt_q[k-1];
                mode_d[k]   = mode_q[k-1];
            end

            data_d[k] = src_data[k];
            if (amt_d[k][k]) begin
                // ASR fills from the current MSB, so the sign survives every stage.
                case (mode_d[k])
                    MODE_ROR: data_d[k] = (src_data[k] >> (1 << k)) | (src_data[k] << (WIDTH - (1 << k)));
                    MODE_ROL: data_d[k] = (src_data[k] << (1 << k)) | (src_data[k] >> (WIDTH - (1 << k)));
                    MODE_LSR: data_d[k] = src_data[k] >> (1 << k);
                    MODE_ASR: data_d[k] = WIDTH'($signed(src_data[k]) >>> (1 << k));
                    default:  data_d[k] = src_data[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int unsigned k = 0; k < AMT_W; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= MODE_ROR;
            end
        end else begin
            for (int unsigned k = 0; k < AMT_W; k++) begin
                if (stage_ready[k]) begin
                    valid_q[k] <= valid_d[k];
                    if (valid_d[k]) begin
                        data_q[k] <= data_d[k];
                        amt_q[k]  <= amt_d[k];
                        mode_q[k] <= mode_d[k];
                    end
                end
            end
            if (stage_ready[AMT_W-1] && valid_d[AMT_W-1]) begin
                zero_q <= (data_d[AMT_W-1] == '0);
            end
        end
    end

    assign in_ready  = stage_ready[0];
    assign out_valid = valid_q[AMT_W-1];
    assign out_data  = data_q[AMT_W-1];
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH=8 (three stages).
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [AMT_W-1:0] in_amt = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    bit         use_force = 1'b0;
    logic [7:0] force_exp = '0;

    // Reference: apply the operation one bit position at a time.
    function automatic logic [7:0] model(input logic [7:0] x, input logic [2:0] n, input logic [1:0] m);
        logic [7:0] r;
        r = x;
        for (int unsigned i = 0; i < n; i++) begin
            case (m)
                2'b00:   r = {r[0], r[7:1]};
                2'b01:   r = {r[6:0], r[7]};
                2'b10:   r = {1'b0, r[7:1]};
                default: r = {r[7], r[7:1]};
            endcase
        end
        return r;
    endfunction

    task automatic new_beat();
        in_data = 8'($urandom);
        in_amt  = 3'($urandom_range(0, 7));
        in_mode = 2'($urandom_range(0, 3));
    endtask

    // One clock: sample at negedge, score the handshakes, return at posedge+1.
    task automatic step(output bit acc, output bit emit);
        logic [7:0] e;
        logic       exp_rdy;
        @(negedge clk);
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        exp_rdy = (exp_q.size() < AMT_W) || out_ready;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b expected %b (in flight %0d)", in_ready, exp_rdy, exp_q.size());
        end
        if (emit) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data %h with no beat outstanding", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e || out_zero !== (e == 8'h00)) begin
                    errors++;
                    $display("FAIL result: got data %h zero %b expected data %h zero %b",
                             out_data, out_zero, e, (e == 8'h00));
                end
            end
        end
        if (acc) exp_q.push_back(use_force ? force_exp : model(in_data, in_amt, in_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic single_beat(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m, input logic [7:0] ex);
        bit acc, emit;
        int lat;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        in_mode   = m;
        use_force = 1'b1;
        force_exp = ex;
        step(acc, emit);
        use_force = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL accept: got %b expected 1", acc);
        end
        lat = 0;
        emit = 1'b0;
        while (!emit && lat < 8) begin
            step(acc, emit);
            lat++;
        end
        checks++;
        if (lat != AMT_W || !emit) begin
            errors++;
            $display("FAIL latency: got %0d cycles (seen %b) expected %0d", lat, emit, AMT_W);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid %b data %h zero %b in_ready %b expected 0 00 0 1",
                     out_valid, out_data, out_zero, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_modes();
        logic [7:0] d_t [9] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'h81, 8'h81, 8'h81, 8'h81, 8'h01};
        logic [2:0] a_t [9] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        logic [1:0] m_t [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2};
        logic [7:0] e_t [9] = '{8'h96, 8'hA5, 8'h16, 8'hF6, 8'h81, 8'h81, 8'h81, 8'h81, 8'h00};
        for (int i = 0; i < 9; i++) single_beat(d_t[i], a_t[i], m_t[i], e_t[i]);
    endtask

    task automatic test_back_to_back();
        bit acc, emit;
        int sent = 0, got = 0, first = -1, last = -1, cyc = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        new_beat();
        while (got < 64 && cyc < 200) begin
            step(acc, emit);
            if (acc) begin
                sent++;
                if (sent < 64) new_beat();
                else in_valid = 1'b0;
            end
            if (emit) begin
                if (got == 0) first = cyc;
                got++;
                if (got == 64) last = cyc;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (got != 64 || last - first != 63) begin
            errors++;
            $display("FAIL stream_gapless: got %0d beats over %0d cycles expected 64 over 63", got, last - first);
        end
    endtask

    task automatic test_backpressure();
        bit acc, emit;
        int acc_cnt = 0, n = 0;
        bit have_prev = 1'b0;
        logic [7:0] prev_data = '0;
        logic       prev_zero = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_beat();
        repeat (6) begin
            step(acc, emit);
            if (acc) begin
                acc_cnt++;
                new_beat();
            end
            if (out_valid) begin
                if (have_prev) begin
                    checks++;
                    if (out_data !== prev_data || out_zero !== prev_zero) begin
                        errors++;
                        $display("FAIL stall_stable: got %h/%b expected %h/%b", out_data, out_zero, prev_data, prev_zero);
                    end
                end
                prev_data = out_data;
                prev_zero = out_zero;
                have_prev = 1'b1;
            end
        end
        checks++;
        if (acc_cnt != AMT_W || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_count: got %0d accepted in_ready %b expected %0d accepted in_ready 0",
                     acc_cnt, in_ready, AMT_W);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_passthrough_ready: got %b expected 1", in_ready);
        end
        step(acc, emit);
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL full_accept: got %b expected 1", acc);
        end
        in_valid = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            step(acc, emit);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d left expected 0", exp_q.size());
        end
    endtask

    task automatic test_random();
        bit acc, emit;
        int sent = 0, cyc = 0, n = 0;
        in_valid = 1'b0;
        while (sent < 1000 && cyc < 6000) begin
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                new_beat();
            end
            step(acc, emit);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
                if ($urandom_range(0, 3) != 0 && sent < 1000) begin
                    in_valid = 1'b1;
                    new_beat();
                end
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 20) begin
            step(acc, emit);
            n++;
        end
        checks++;
        if (sent != 1000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_total: got %0d sent %0d pending expected 1000 sent 0 pending", sent, exp_q.size());
        end
    endtask

    task automatic test_reset_inflight();
        bit acc, emit;
        int stale = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (3) begin
            new_beat();
            step(acc, emit);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_zero !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: got valid %b data %h zero %b in_ready %b expected 0 00 0 1",
                     out_valid, out_data, out_zero, in_ready);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            step(acc, emit);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_after_reset: got %0d valid cycles expected 0", stale);
        end
        single_beat(8'h5A, 3'd1, 2'd1, 8'hB4);
    endtask

    initial begin
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_inflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
